// File: rtl/mdu_defs_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and arithmetic result payload.
package mdu_defs;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned WIDTH_MD_OP    = 3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MULT  = 3'd0;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MULTU = 3'd1;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_DIV   = 3'd2;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_DIVU  = 3'd3;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MTHI  = 3'd4;
    localparam logic [WIDTH_MD_OP-1:0] MD_OP_MTLO  = 3'd5;

    typedef struct packed {
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot;
        logic [XLEN-1:0]   rem;
        logic              div_zero;
        logic              div_ovf;
    } md_arith_t;

    function automatic logic is_mul(input logic [WIDTH_MD_OP-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [WIDTH_MD_OP-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational 64-bit product and quotient/remainder with div-by-zero and overflow flags.
module mdu_arith
    import mdu_defs::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            signed_i,
    output md_arith_t       res_o
);

    logic dz_c;
    logic ovf_c;

    assign dz_c  = (b_i == '0);
    assign ovf_c = signed_i && (a_i == 32'h8000_0000) && (b_i == '1);

    always_comb begin
        res_o          = '0;
        res_o.div_zero = dz_c;
        res_o.div_ovf  = ovf_c;
        if (signed_i) begin
            res_o.prod = 64'($signed(a_i)) * 64'($signed(b_i));
        end else begin
            res_o.prod = {32'b0, a_i} * {32'b0, b_i};
        end
        // Zero divisor leaves quot/rem at 0; the controller never commits them.
        if (dz_c) begin
            res_o.quot = '0;
            res_o.rem  = '0;
        end else if (ovf_c) begin
            res_o.quot = 32'h8000_0000;
            res_o.rem  = '0;
        end else if (signed_i) begin
            res_o.quot = $signed(a_i) / $signed(b_i);
            res_o.rem  = $signed(a_i) % $signed(b_i);
        end else begin
            res_o.quot = a_i / b_i;
            res_o.rem  = a_i % b_i;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller: fixed-latency countdown, pending result commit and ID stall request.
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [WIDTH_MD_OP-1:0] op,
    input  logic [XLEN-1:0]        rs_data,
    input  logic [XLEN-1:0]        rt_data,
    input  logic                   flush,
    input  logic                   md_use_ID,
    output logic                   busy,
    output logic                   done,
    output logic                   stall_md,
    output logic [XLEN-1:0]        hi,
    output logic [XLEN-1:0]        lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic             p_dz_q, p_dz_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             muldiv_c;
    md_arith_t        arith_c;

    mdu_arith u_arith (
        .a_i      (rs_data),
        .b_i      (rt_data),
        .signed_i ((op == MD_OP_MULT) || (op == MD_OP_DIV)),
        .res_o    (arith_c)
    );

    assign muldiv_c = is_mul(op) || is_div(op);

    // Next-state: launch from idle, count down in run, commit on the final edge.
    always_comb begin
        cnt_d  = cnt_q;
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        p_dz_d = p_dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (flush) begin
            cnt_d  = '0;
            p_hi_d = '0;
            p_lo_d = '0;
            p_dz_d = 1'b0;
        end else if (cnt_q == '0) begin
            if (start) begin
                if (is_mul(op)) begin
                    cnt_d  = CNT_W'(MULT_CYCLES);
                    p_hi_d = arith_c.prod[2*XLEN-1:XLEN];
                    p_lo_d = arith_c.prod[XLEN-1:0];
                    p_dz_d = 1'b0;
                end else if (is_div(op)) begin
                    cnt_d  = CNT_W'(DIV_CYCLES);
                    p_hi_d = arith_c.rem;
                    p_lo_d = arith_c.quot;
                    p_dz_d = arith_c.div_zero;
                end else if (op == MD_OP_MTHI) begin
                    hi_d = rs_data;
                end else if (op == MD_OP_MTLO) begin
                    lo_d = rs_data;
                end
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                done_d = 1'b1;
                if (!p_dz_q) begin
                    hi_d = p_hi_q;
                    lo_d = p_lo_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            p_dz_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            p_dz_q <= p_dz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    // The hazard unit keeps MD ops out of EX while one is in flight.
    always_ff @(posedge clk) begin
        if (reset_n && start && !flush) begin
            assert (cnt_q == '0);
        end
    end

    assign busy     = (cnt_q != '0);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_use_ID && (busy || (start && muldiv_c));

endmodule
